serializer: RTL and testbench

- Parallel-to-serial transmitter. It is the transmit end of the team's serial link, and its output feeds the deserializer on the far side.
- Accepts a DATA_WIDTH-bit word through a valid/ready handshake.
- Shifts the word out one bit per enabled cycle, MSB-first or LSB-first.
- Flags every bit as valid and marks the last bit of each word. Supports gapless back-to-back words.

---
 rtl/serializer.sv | 117 +++++++++++
 tb/tb_serializer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// serializer: parallel-to-serial transmitter for the serial link.
//
// A DATA_WIDTH-bit word is accepted through a valid/ready handshake and
// shifted out one bit per enabled cycle, MSB-first (dir=1) or LSB-first
// (dir=0). Every bit is flagged valid and the final bit of each word is
// marked with ser_last. A new word can be taken on the last-bit cycle,
// which gives gapless back-to-back output.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous, active-low reset
//   dir        bit order, sampled at word accept (1 = MSB first)
//   par_valid  upstream word available
//   par_ready  word can be accepted this cycle (combinational)
//   par        parallel word, taken when par_valid && par_ready
//   ser_en     downstream bit enable; a bit moves when ser_valid && ser_en
//   ser        serial data bit (0 whenever ser_valid is 0)
//   ser_valid  ser holds a bit of the current word
//   ser_last   current bit is the final bit of the word
//   busy       word in flight
module serializer #(
    parameter int DATA_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dir,
    input  logic                  par_valid,
    output logic                  par_ready,
    input  logic [DATA_WIDTH-1:0] par,
    input  logic                  ser_en,
    output logic                  ser,
    output logic                  ser_valid,
    output logic                  ser_last,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  dir_q, dir_d;
    logic                  at_last;
    logic                  accept;

    // Values above LAST cannot arise in normal operation; treating them as
    // the last bit guarantees the word always terminates.
    assign at_last = (cnt_q >= LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        par_ready = 1'b0;
        accept    = 1'b0;

        case (state_q)
            IDLE: begin
                par_ready = 1'b1;
                accept    = par_valid;
                if (accept) begin
                    sreg_d  = par;
                    dir_d   = dir;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                par_ready = ser_en && at_last;
                accept    = par_valid && par_ready;
                if (ser_en) begin
                    if (!at_last) begin
                        sreg_d = dir_q ? {sreg_q[DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, sreg_q[DATA_WIDTH-1:1]};
                        cnt_d  = cnt_q + 1'b1;
                    end else if (accept) begin
                        sreg_d = par;
                        dir_d  = dir;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from flop state only, so they change only on a
    // clock edge or on reset assertion.
    assign ser_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign ser       = ser_valid && (dir_q ? sreg_q[DATA_WIDTH-1] : sreg_q[0]);
    assign ser_last  = ser_valid && at_last;

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         dir;
    logic         par_valid;
    logic         par_ready;
    logic [W-1:0] par;
    logic         ser_en;
    logic         ser;
    logic         ser_valid;
    logic         ser_last;
    logic         busy;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {bit, last} pairs and expected {dir, word}.
    logic [1:0]   bit_q[$];
    logic [W:0]   word_q[$];
    logic [W-1:0] acc;
    int           nbits;
    int           words_done;
    int           valid_cycles;

    serializer #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dir       (dir),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .par       (par),
        .ser_en    (ser_en),
        .ser       (ser),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bit_q.delete();
            word_q.delete();
            nbits = 0;
            acc   = '0;
        end else begin
            if (ser_valid) valid_cycles++;
            if (!ser_valid) check("ser_zero_when_idle", {31'd0, ser}, 32'd0);
            if (ser_valid && ser_en) begin
                if (bit_q.size() == 0) begin
                    check("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = bit_q.pop_front();
                    check("ser_bit", {31'd0, ser}, {31'd0, e[1]});
                    check("ser_last_flag", {31'd0, ser_last}, {31'd0, e[0]});
                end
                if (word_q.size() != 0) begin
                    if (word_q[0][W]) acc = {acc[W-2:0], ser};
                    else              acc = {ser, acc[W-1:1]};
                end
                nbits++;
                if (ser_last) begin
                    if (word_q.size() == 0) begin
                        check("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        logic [W:0] ew;
                        ew = word_q.pop_front();
                        check("word_rx", 32'(acc), 32'(ew[W-1:0]));
                        check("word_len", 32'(nbits), 32'(W));
                    end
                    nbits = 0;
                    words_done++;
                end
            end
            if (par_valid && par_ready) begin
                for (int unsigned i = 0; i < W; i++) begin
                    int unsigned k;
                    k = dir ? (W - 1 - i) : i;
                    bit_q.push_back({par[k], (i == W - 1) ? 1'b1 : 1'b0});
                end
                word_q.push_back({dir, par});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_bits;
        int           cyc;
        int           sent;
        words_done   = 0;
        valid_cycles = 0;
        nbits        = 0;
        acc          = '0;
        rst_n        = 1'b0;
        dir          = 1'b0;
        par_valid    = 1'b0;
        par          = '0;
        ser_en       = 1'b0;

        // Reset state
        #2;
        check("rst_ser_valid", {31'd0, ser_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ser_last", {31'd0, ser_last}, 32'd0);
        check("rst_par_ready", {31'd0, par_ready}, 32'd1);
        // Offer a word while reset is still low: it must not be taken.
        par_valid = 1'b1; par = 5'b11111; dir = 1'b1;
        tick(); tick();
        check("rst_hold_idle", {31'd0, busy}, 32'd0);
        par_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // 1: MSB-first word
        exp_bits = 5'b10110;
        dir = 1'b1; par = 5'b10110; par_valid = 1'b1; ser_en = 1'b1;
        tick();
        par_valid = 1'b0;
        valid_cycles = 0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("t1_ser", {31'd0, ser}, {31'd0, exp_bits[W-1-i]});
            check("t1_last", {31'd0, ser_last}, (i == W - 1) ? 32'd1 : 32'd0);
            check("t1_ready", {31'd0, par_ready}, (i == W - 1) ? 32'd1 : 32'd0);
            tick();
        end
        @(negedge clk);
        check("t1_valid_cycles", 32'(valid_cycles), 32'd5);
        check("t1_idle_ready", {31'd0, par_ready}, 32'd1);
        check("t1_idle_valid", {31'd0, ser_valid}, 32'd0);
        tick();

        // 2: LSB-first, dir toggled mid-word
        exp_bits = 5'b10110;
        dir = 1'b0; par = 5'b10110; par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            dir = ~dir;
            @(negedge clk);
            check("t2_ser", {31'd0, ser}, {31'd0, exp_bits[i]});
            tick();
        end
        tick();

        // 3: back-to-back 5'h15 then 5'h0A, MSB first
        dir = 1'b1; par = 5'h15; par_valid = 1'b1;
        tick();
        par = 5'h0A;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            check("t3_valid", {31'd0, ser_valid}, 32'd1);
            check("t3_ser", {31'd0, ser}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("t3_ready", {31'd0, par_ready}, (i == W - 1 || i == 2 * W - 1) ? 32'd1 : 32'd0);
            tick();
            if (i == W - 1) par_valid = 1'b0;
        end
        @(negedge clk);
        check("t3_done", {31'd0, busy}, 32'd0);
        tick();

        // 4: stall for 3 cycles while the 2nd bit is presented
        dir = 1'b1; par = 5'b10110; par_valid = 1'b1; ser_en = 1'b1;
        tick();
        par_valid = 1'b0;
        valid_cycles = 0;
        tick();
        ser_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_stall_ser", {31'd0, ser}, 32'd0);
            check("t4_stall_valid", {31'd0, ser_valid}, 32'd1);
            check("t4_stall_last", {31'd0, ser_last}, 32'd0);
            tick();
        end
        ser_en = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        check("t4_total_cycles", 32'(valid_cycles), 32'd8);
        check("t4_done", {31'd0, busy}, 32'd0);
        tick();

        // 5: reset mid-word after bit 3
        dir = 1'b1; par = 5'b11111; par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("t5_ser", {31'd0, ser}, 32'd0);
        check("t5_valid", {31'd0, ser_valid}, 32'd0);
        check("t5_last", {31'd0, ser_last}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_ready", {31'd0, par_ready}, 32'd1);
        tick();
        exp_bits = 5'b01101;
        par = 5'b01101; par_valid = 1'b1;
        tick();
        par_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("t5_post_ser", {31'd0, ser}, {31'd0, exp_bits[W-1-i]});
            tick();
        end
        tick();

        // 6: random loopback, 200 words with random gaps and stalls
        words_done = 0;
        sent = 0;
        cyc = 0;
        par_valid = 1'b0;
        while (sent < 200 && cyc < 20000) begin
            logic acc_now;
            if (!par_valid && $urandom_range(0, 3) != 0) begin
                par_valid = 1'b1;
                par = W'($urandom);
                dir = 1'($urandom);
            end
            ser_en = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc_now = par_valid && par_ready;
            tick();
            cyc++;
            if (acc_now) begin
                sent++;
                par_valid = 1'b0;
            end
        end
        par_valid = 1'b0;
        ser_en = 1'b1;
        cyc = 0;
        while (words_done < 200 && cyc < 1000) begin
            tick();
            cyc++;
        end
        check("t6_words", 32'(words_done), 32'd200);
        check("t6_queue_empty", 32'(bit_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
